// File: rtl/count_seq_checker.sv
// Sequence checker for an external 3-bit up-counter: flags broken count steps,
// counts violations (saturating) and 7->0 rollovers, and pulses on a selectable value.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no reference yet; next sample must be 0 to start tracking
// TRACK  | each sample checked against prev_cnt (+1 when prev_en)
// RESYNC | after a violation; current sample taken as the new reference
// 2'b11  | illegal encoding; recovers to IDLE
module count_seq_checker #(
   parameter int ERR_W  = 8,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        cnt_in,
   input  logic              cnt_en,
   input  logic              clr,
   input  logic [2:0]        match_val,
   output logic              match_pulse,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_TRACK  = 2'b01,
      ST_RESYNC = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t     st;
   state_t     nxt_st;
   logic [2:0] prev_cnt;
   logic       prev_en;
   logic [2:0] exp_cnt;
   logic       seq_err;
   logic       do_wrap;
   logic       do_match;
   logic       err_sat;
   logic       hit;

   // 3-bit addition wraps 7 -> 0 naturally
   assign exp_cnt = prev_en ? (prev_cnt + 3'd1) : prev_cnt;
   assign hit     = (cnt_in == match_val);
   assign err_sat = (err_cnt == {ERR_W{1'b1}});

   always_comb begin
      nxt_st   = ST_IDLE;
      seq_err  = 1'b0;
      do_wrap  = 1'b0;
      do_match = 1'b0;
      case (st)
         ST_IDLE: begin
            do_match = hit;
            if (cnt_in == 3'd0) begin
               nxt_st = ST_TRACK;
            end else begin
               nxt_st  = ST_RESYNC;
               seq_err = 1'b1;
            end
         end
         ST_TRACK: begin
            do_match = hit;
            if (cnt_in != exp_cnt) begin
               nxt_st  = ST_RESYNC;
               seq_err = 1'b1;
            end else begin
               nxt_st  = ST_TRACK;
               do_wrap = prev_en && (prev_cnt == 3'd7) && (cnt_in == 3'd0);
            end
         end
         ST_RESYNC: begin
            nxt_st = ST_TRACK;
         end
         default: begin
            nxt_st = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st          <= ST_IDLE;
         prev_cnt    <= 3'd0;
         prev_en     <= 1'b0;
         match_pulse <= 1'b0;
         err_pulse   <= 1'b0;
         err_cnt     <= '0;
         wrap_cnt    <= '0;
      end else begin
         prev_cnt <= cnt_in;
         prev_en  <= cnt_en;
         if (clr) begin
            st          <= ST_IDLE;
            match_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            wrap_cnt    <= '0;
         end else begin
            st          <= nxt_st;
            match_pulse <= do_match;
            err_pulse   <= seq_err;
            if (seq_err && !err_sat) begin
               err_cnt <= err_cnt + ERR_W'(1);
            end
            if (do_wrap) begin
               wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker; expected values are hand-derived per step.
module tb_count_seq_checker;

   logic       clk;
   logic       reset_n;
   logic [2:0] cnt_in;
   logic       cnt_en;
   logic       clr;
   logic [2:0] match_val;
   logic       match_pulse;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic [7:0] wrap_cnt;
   logic [1:0] state;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] TRACK  = 2'b01;
   localparam logic [1:0] RESYNC = 2'b10;

   count_seq_checker #(.ERR_W(8), .WRAP_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cnt_in     (cnt_in),
      .cnt_en     (cnt_en),
      .clr        (clr),
      .match_val  (match_val),
      .match_pulse(match_pulse),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt),
      .wrap_cnt   (wrap_cnt),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [2:0] c, input logic e);
      cnt_in = c;
      cnt_en = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr     = 1'b0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, 32'(state), 32'(IDLE));
      chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
      chk({tag, "_wrap_cnt"}, 32'(wrap_cnt), 0);
      chk({tag, "_err_pulse"}, 32'(err_pulse), 0);
      chk({tag, "_match_pulse"}, 32'(match_pulse), 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      cnt_in    = 3'd0;
      cnt_en    = 1'b0;
      clr       = 1'b0;
      match_val = 3'd0;

      // reset holds everything at zero, with and without clock edges
      #2;
      chk_all_zero("rst_async");
      cnt_in = 3'd3;
      cnt_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all_zero("rst_clocked");

      // full count 0..7,0,1
      reset_n   = 1'b1;
      match_val = 3'd5;
      step(3'd0, 1'b1);
      chk("a_first_state", 32'(state), 32'(TRACK));
      chk("a_first_err", 32'(err_pulse), 0);
      for (int i = 1; i < 10; i++) begin
         step(3'(i % 8), 1'b1);
         chk("a_err_pulse", 32'(err_pulse), 0);
      end
      chk("a_state", 32'(state), 32'(TRACK));
      chk("a_err_cnt", 32'(err_cnt), 0);
      chk("a_wrap_cnt", 32'(wrap_cnt), 1);

      // match pulses, including repeated pulses while holding
      do_reset();
      match_val = 3'd5;
      for (int i = 0; i < 5; i++) begin
         step(3'(i), 1'b1);
         chk("b_no_match", 32'(match_pulse), 0);
      end
      step(3'd5, 1'b0);
      chk("b_match_first", 32'(match_pulse), 1);
      for (int i = 0; i < 3; i++) begin
         step(3'd5, 1'b0);
         chk("b_match_hold", 32'(match_pulse), 1);
         chk("b_hold_err", 32'(err_pulse), 0);
      end
      step(3'd5, 1'b1);
      chk("b_match_last_hold", 32'(match_pulse), 1);
      step(3'd6, 1'b1);
      chk("b_match_off", 32'(match_pulse), 0);

      // skip 3->6, resync on 7, wrap on 0
      do_reset();
      match_val = 3'd7;
      step(3'd0, 1'b1);
      step(3'd1, 1'b1);
      step(3'd2, 1'b1);
      step(3'd3, 1'b1);
      chk("c_pre_err", 32'(err_pulse), 0);
      step(3'd6, 1'b1);
      chk("c_err_pulse", 32'(err_pulse), 1);
      chk("c_err_cnt", 32'(err_cnt), 1);
      chk("c_state_resync", 32'(state), 32'(RESYNC));
      step(3'd7, 1'b1);
      chk("c_resync_err", 32'(err_pulse), 0);
      chk("c_resync_nomatch", 32'(match_pulse), 0);
      chk("c_state_track", 32'(state), 32'(TRACK));
      step(3'd0, 1'b1);
      chk("c_wrap_err", 32'(err_pulse), 0);
      chk("c_wrap_cnt", 32'(wrap_cnt), 1);
      chk("c_err_cnt_hold", 32'(err_cnt), 1);

      // first sample nonzero: error and match together
      do_reset();
      match_val = 3'd3;
      step(3'd3, 1'b1);
      chk("d_err_pulse", 32'(err_pulse), 1);
      chk("d_match_with_err", 32'(match_pulse), 1);
      chk("d_err_cnt", 32'(err_cnt), 1);
      chk("d_state", 32'(state), 32'(RESYNC));
      match_val = 3'd4;
      step(3'd4, 1'b1);
      chk("d_resync_nomatch", 32'(match_pulse), 0);
      chk("d_resync_err", 32'(err_pulse), 0);
      chk("d_state_track", 32'(state), 32'(TRACK));
      match_val = 3'd5;
      step(3'd5, 1'b1);
      chk("d_track_err", 32'(err_pulse), 0);
      chk("d_match_same_cycle", 32'(match_pulse), 1);
      chk("d_err_cnt_hold", 32'(err_cnt), 1);
      chk("d_state_track2", 32'(state), 32'(TRACK));

      // 300 violations: stuck at 3 with enable errors every other sample
      do_reset();
      match_val = 3'd0;
      for (int i = 1; i <= 509; i++) step(3'd3, 1'b1);
      chk("e_err_cnt_255", 32'(err_cnt), 255);
      for (int i = 510; i <= 599; i++) step(3'd3, 1'b1);
      chk("e_last_err_pulse", 32'(err_pulse), 1);
      chk("e_err_cnt_sat", 32'(err_cnt), 255);

      // clr mid-count at 4
      do_reset();
      match_val = 3'd4;
      step(3'd5, 1'b1);
      step(3'd6, 1'b1);
      step(3'd7, 1'b1);
      step(3'd0, 1'b1);
      step(3'd1, 1'b1);
      step(3'd2, 1'b1);
      step(3'd3, 1'b1);
      chk("f_pre_err_cnt", 32'(err_cnt), 1);
      chk("f_pre_wrap_cnt", 32'(wrap_cnt), 1);
      clr = 1'b1;
      step(3'd4, 1'b1);
      clr = 1'b0;
      chk_all_zero("f_clr");
      step(3'd0, 1'b1);
      chk("f_after_clr_state", 32'(state), 32'(TRACK));
      chk("f_after_clr_err", 32'(err_pulse), 0);

      // reset mid-count at 4
      do_reset();
      step(3'd5, 1'b1);
      step(3'd6, 1'b1);
      step(3'd7, 1'b1);
      step(3'd0, 1'b1);
      step(3'd1, 1'b1);
      step(3'd2, 1'b1);
      step(3'd3, 1'b1);
      chk("g_pre_wrap_cnt", 32'(wrap_cnt), 1);
      cnt_in  = 3'd4;
      reset_n = 1'b0;
      #1;
      chk_all_zero("g_rst_async");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(3'd0, 1'b1);
      chk("g_after_rst_state", 32'(state), 32'(TRACK));
      chk("g_after_rst_err", 32'(err_pulse), 0);
      chk("g_after_rst_err_cnt", 32'(err_cnt), 0);
      step(3'd1, 1'b1);
      chk("g_after_rst_track", 32'(err_pulse), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
